rotary_quad_ctrl: RTL and testbench
===================================

ROTARY_QUAD_CTRL -- requirements
Module: rotary_quad_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 11: count and address width.
REQ-002 SHALL have parameter DEB_CYC, default 16: stable-sample cycles for the debounce filter.
REQ-003 SHALL have parameter TMO_CYC, default 65535: detent-completion timeout, in cycles.
REQ-004 SHALL have parameter UPD_PERIOD, default 2401: cycles between address updates.
REQ-005 SHALL have parameters STEP0, STEP1, STEP2, defaults 1, 10, 100: selectable step sizes.
REQ-006 SHALL have port Fg_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port Reset, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have ports Rot_A and Rot_B, input, 1 bit each: raw quadrature encoder phases, asynchronous.
REQ-009 SHALL have port Rot_C, input, 1 bit: raw push button, asynchronous, active-high.
REQ-010 SHALL have ports Lo_lim and Hi_lim, input, CNT_W bits each: inclusive count limits, quasi-static.
REQ-011 SHALL have port address, output, CNT_W bits: published count.
REQ-012 SHALL have port FreqChng, output, 1 bit: one-cycle pulse when address takes a new value.
REQ-013 SHALL have port Step_sel, output, 2 bits: active step index, 0 to 2.

Function
REQ-014 SHALL pass Rot_A, Rot_B and Rot_C each through a 2-FF synchroniser, then a debounce filter.
REQ-015 Debounce filter SHALL change its output only after the synchronised input has differed from that output for DEB_CYC consecutive cycles; any mismatch break restarts the filter counter at 0.
REQ-016 SHALL generate single-cycle falling-edge pulses A_fall and B_fall from the filtered A and B, and a rising-edge pulse C_rise from the filtered C.
REQ-017 The FSM SHALL have three states: IDLE, CW_WAIT and CCW_WAIT.
REQ-018 In IDLE, B_fall alone SHALL increment the count and move the FSM to CW_WAIT; A_fall alone SHALL decrement the count and move the FSM to CCW_WAIT; A_fall and B_fall in the same cycle SHALL leave the count unchanged and the FSM in IDLE.
REQ-019 In CW_WAIT, A_fall SHALL return the FSM to IDLE; in CCW_WAIT, B_fall SHALL return the FSM to IDLE; all other edges in these states SHALL be ignored.
REQ-020 In CW_WAIT or CCW_WAIT, TMO_CYC cycles without the completing edge SHALL force the FSM to IDLE with no count change.
REQ-021 An increment SHALL compute count+step at CNT_W+1 bits and saturate at Hi_lim.
REQ-022 A decrement SHALL saturate at Lo_lim whenever count < Lo_lim+step (compare at CNT_W+1 bits, so there is no underflow wrap).
REQ-023 Every cycle, a count outside [Lo_lim, Hi_lim] SHALL be clamped to the nearer limit; the clamp SHALL take priority over a same-cycle rotation, and that rotation is dropped.
REQ-024 If Lo_lim > Hi_lim, the count SHALL be held at Lo_lim.
REQ-025 C_rise SHALL advance Step_sel 0 -> 1 -> 2 -> 0, exactly one advance per press regardless of hold time; step = STEP0, STEP1 or STEP2 by Step_sel.
REQ-026 A new step value SHALL apply from the cycle after C_rise.
REQ-027 The period counter SHALL run 0 to UPD_PERIOD-1 and wrap; at terminal count (tick), address SHALL load the count.
REQ-028 On the same clock edge as a tick, FreqChng SHALL be set to (count != address_old); FreqChng SHALL be 0 on all other cycles.

Reset
REQ-029 Reset SHALL asynchronously set: synchronisers and filters for A/B to 1 and for C to 0, FSM to IDLE, count to 0, Step_sel to 0, period counter to 0, address to 0, FreqChng to 0.
REQ-030 After Reset deasserts, the first clock cycle SHALL apply the limit clamp to the count (0 becomes Lo_lim if Lo_lim > 0).
REQ-031 Reset asserted mid-detent or mid-debounce SHALL abandon that operation with no count change.

Structure
REQ-032 Shared package rotary_pkg SHALL hold the FSM state enum, the 2-bit step-index typedef and the default parameter constants.
REQ-033 The debounce filter SHALL be sub-module rot_debounce (parameter DEB_CYC), instantiated three times.

Verification
REQ-034 Lo_lim=0, Hi_lim=1800, Step_sel=0; 5 clean CW detents (B falls, then A falls) -> count 5; at next tick, address=5 with a single FreqChng pulse.
REQ-035 Step_sel=2, count=1750, one CW detent -> count 1800 (saturated); one CCW detent from count 50 with Lo_lim=0 -> count 0, no wrap.
REQ-036 Rot_A glitch shorter than DEB_CYC cycles -> no A_fall, count unchanged.
REQ-037 Rot_C held 10000 cycles -> Step_sel advances once only (0 -> 1).
REQ-038 B falls, then A held high longer than TMO_CYC cycles -> FSM returns to IDLE, count +1 only; the next B falls -> a further +1.
REQ-039 count=300, Lo_lim changed to 800 -> count 800 the next cycle; tick with count equal to address -> FreqChng remains 0.

Source files
------------

// File: rtl/rotary_pkg.sv
// Shared types and default constants for the rotary quadrature controller.
package rotary_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCwWait  = 2'd1,
    StCcwWait = 2'd2
  } rot_state_e;

  typedef logic [1:0] step_idx_t;

  localparam int unsigned DefCntW      = 11;
  localparam int unsigned DefDebCyc    = 16;
  localparam int unsigned DefTmoCyc    = 65535;
  localparam int unsigned DefUpdPeriod = 2401;
  localparam int unsigned DefStep0     = 1;
  localparam int unsigned DefStep1     = 10;
  localparam int unsigned DefStep2     = 100;

  // Step index cycles 0 -> 1 -> 2 -> 0.
  function automatic step_idx_t next_step_idx(input step_idx_t idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/rot_debounce.sv
// Debounce filter: output follows input only after DEB_CYC consecutive mismatching samples.
module rot_debounce #(
  parameter int unsigned DEB_CYC = 16,
  parameter bit          RST_VAL = 1'b0
) (
  input  logic Fg_clk,
  input  logic Reset,
  input  logic din,
  output logic dout
);

  localparam int unsigned CntW = $clog2(DEB_CYC + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            out_q, out_d;

  // Any sample that agrees with the output restarts the count at zero.
  always_comb begin
    cnt_d = '0;
    out_d = out_q;
    if (din != out_q) begin
      if (cnt_q == CntW'(DEB_CYC - 1)) begin
        out_d = din;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge Fg_clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
      out_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign dout = out_q;

endmodule

// File: rtl/rotary_quad_ctrl.sv
// Rotary encoder front end: debounced quadrature decode into a limited, step-selectable
// count that is published to address at a fixed update period.
module rotary_quad_ctrl
  import rotary_pkg::*;
#(
  parameter int unsigned CNT_W      = DefCntW,
  parameter int unsigned DEB_CYC    = DefDebCyc,
  parameter int unsigned TMO_CYC    = DefTmoCyc,
  parameter int unsigned UPD_PERIOD = DefUpdPeriod,
  parameter int unsigned STEP0      = DefStep0,
  parameter int unsigned STEP1      = DefStep1,
  parameter int unsigned STEP2      = DefStep2
) (
  input  logic             Fg_clk,
  input  logic             Reset,
  input  logic             Rot_A,
  input  logic             Rot_B,
  input  logic             Rot_C,
  input  logic [CNT_W-1:0] Lo_lim,
  input  logic [CNT_W-1:0] Hi_lim,
  output logic [CNT_W-1:0] address,
  output logic             FreqChng,
  output logic [1:0]       Step_sel
);

  localparam int unsigned SumW = CNT_W + 1;
  localparam int unsigned TmoW = $clog2(TMO_CYC + 1);
  localparam int unsigned PerW = $clog2(UPD_PERIOD + 1);
  // Bit order {C, B, A}: phases idle high, button idles low.
  localparam logic [2:0]  InRst = 3'b011;

  logic [2:0]       sync1_q, sync2_q, prev_q, filt;
  logic             a_fall, b_fall, c_rise;
  rot_state_e       state_q, state_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic             inc, dec;
  logic [CNT_W-1:0] count_q, count_d, address_q, address_d;
  logic [SumW-1:0]  step_w, lo_w, hi_w, cnt_w, sum_w;
  step_idx_t        step_sel_q, step_sel_d;
  logic [PerW-1:0]  per_q, per_d;
  logic             tick, freq_q, freq_d;

  rot_debounce #(.DEB_CYC(DEB_CYC), .RST_VAL(1'b1)) u_deb_a (
    .Fg_clk(Fg_clk), .Reset(Reset), .din(sync2_q[0]), .dout(filt[0])
  );
  rot_debounce #(.DEB_CYC(DEB_CYC), .RST_VAL(1'b1)) u_deb_b (
    .Fg_clk(Fg_clk), .Reset(Reset), .din(sync2_q[1]), .dout(filt[1])
  );
  rot_debounce #(.DEB_CYC(DEB_CYC), .RST_VAL(1'b0)) u_deb_c (
    .Fg_clk(Fg_clk), .Reset(Reset), .din(sync2_q[2]), .dout(filt[2])
  );

  assign a_fall = prev_q[0] & ~filt[0];
  assign b_fall = prev_q[1] & ~filt[1];
  assign c_rise = ~prev_q[2] & filt[2];

  always_comb begin
    state_d = state_q;
    tmo_d   = '0;
    inc     = 1'b0;
    dec     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (b_fall && !a_fall) begin
          inc     = 1'b1;
          state_d = StCwWait;
        end else if (a_fall && !b_fall) begin
          dec     = 1'b1;
          state_d = StCcwWait;
        end
      end
      StCwWait: begin
        if (a_fall || tmo_q == TmoW'(TMO_CYC - 1)) begin
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StCcwWait: begin
        if (b_fall || tmo_q == TmoW'(TMO_CYC - 1)) begin
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Count arithmetic is one bit wider so neither saturation test can wrap.
  always_comb begin
    case (step_sel_q)
      2'd1:    step_w = SumW'(STEP1);
      2'd2:    step_w = SumW'(STEP2);
      default: step_w = SumW'(STEP0);
    endcase
    lo_w    = {1'b0, Lo_lim};
    hi_w    = {1'b0, Hi_lim};
    cnt_w   = {1'b0, count_q};
    sum_w   = cnt_w + step_w;
    count_d = count_q;
    if (lo_w > hi_w || cnt_w < lo_w) begin
      count_d = Lo_lim;
    end else if (cnt_w > hi_w) begin
      count_d = Hi_lim;
    end else if (inc) begin
      count_d = (sum_w > hi_w) ? Hi_lim : sum_w[CNT_W-1:0];
    end else if (dec) begin
      count_d = (cnt_w < lo_w + step_w) ? Lo_lim : count_q - step_w[CNT_W-1:0];
    end
  end

  always_comb begin
    step_sel_d = c_rise ? next_step_idx(step_sel_q) : step_sel_q;
    tick       = (per_q == PerW'(UPD_PERIOD - 1));
    per_d      = tick ? '0 : per_q + PerW'(1);
    address_d  = tick ? count_q : address_q;
    freq_d     = tick && (count_q != address_q);
  end

  always_ff @(posedge Fg_clk or posedge Reset) begin
    if (Reset) begin
      sync1_q    <= InRst;
      sync2_q    <= InRst;
      prev_q     <= InRst;
      state_q    <= StIdle;
      tmo_q      <= '0;
      count_q    <= '0;
      step_sel_q <= 2'd0;
      per_q      <= '0;
      address_q  <= '0;
      freq_q     <= 1'b0;
    end else begin
      sync1_q    <= {Rot_C, Rot_B, Rot_A};
      sync2_q    <= sync1_q;
      prev_q     <= filt;
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      count_q    <= count_d;
      step_sel_q <= step_sel_d;
      per_q      <= per_d;
      address_q  <= address_d;
      freq_q     <= freq_d;
    end
  end

  assign address  = address_q;
  assign FreqChng = freq_q;
  assign Step_sel = step_sel_q;

endmodule

// File: tb/tb_rotary_quad_ctrl.sv
// Scoreboarded bench: stimulus pushes expected published addresses, a monitor pops on FreqChng.
module tb_rotary_quad_ctrl;

  localparam int unsigned CNT_W      = 11;
  localparam int unsigned DEB_CYC    = 4;
  localparam int unsigned TMO_CYC    = 200;
  localparam int unsigned UPD_PERIOD = 401;
  localparam int          E          = DEB_CYC + 6;

  logic             Fg_clk = 1'b0;
  logic             Reset, Rot_A, Rot_B, Rot_C;
  logic [CNT_W-1:0] Lo_lim, Hi_lim, address;
  logic             FreqChng;
  logic [1:0]       Step_sel;

  int vectors     = 0;
  int miscompares = 0;
  int exp_q[$];
  int step_tbl[3] = '{1, 10, 100};
  int m_count, m_pub, m_sel, m_lo, m_hi;

  rotary_quad_ctrl #(
    .CNT_W(CNT_W), .DEB_CYC(DEB_CYC), .TMO_CYC(TMO_CYC), .UPD_PERIOD(UPD_PERIOD),
    .STEP0(1), .STEP1(10), .STEP2(100)
  ) dut (
    .Fg_clk(Fg_clk), .Reset(Reset), .Rot_A(Rot_A), .Rot_B(Rot_B), .Rot_C(Rot_C),
    .Lo_lim(Lo_lim), .Hi_lim(Hi_lim), .address(address), .FreqChng(FreqChng),
    .Step_sel(Step_sel)
  );

  always #5 Fg_clk = ~Fg_clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every FreqChng pulse must match the oldest outstanding expectation.
  always @(negedge Fg_clk) begin
    if (!Reset && FreqChng) begin
      if (exp_q.size() == 0) begin
        check("freqchng_unexpected", int'(FreqChng), 0);
      end else begin
        check("address_at_freqchng", int'(address), exp_q.pop_front());
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge Fg_clk);
  endtask

  function automatic int clamp(input int c);
    if (m_lo > m_hi || c < m_lo) return m_lo;
    if (c > m_hi) return m_hi;
    return c;
  endfunction

  task automatic publish();
    if (m_count != m_pub) begin
      exp_q.push_back(m_count);
      m_pub = m_count;
    end
  endtask

  // Wait for outstanding publishes (bounded), or a full period if none, then check address.
  task automatic settle();
    int n = 0;
    while (exp_q.size() != 0 && n < 2 * UPD_PERIOD) begin
      @(posedge Fg_clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("publish_timeout_pending", exp_q.size(), 0);
      exp_q.delete();
    end
    if (n == 0) cycles(UPD_PERIOD + 2);
    else cycles(2);
    @(negedge Fg_clk);
    check("address_settled", int'(address), m_pub);
  endtask

  task automatic detent(input bit cw, input bit push);
    int s = step_tbl[m_sel];
    if (cw) m_count = (m_count + s > m_hi) ? m_hi : m_count + s;
    else    m_count = (m_count < m_lo + s) ? m_lo : m_count - s;
    if (push) publish();
    if (cw) begin
      Rot_B = 1'b0; cycles(E); Rot_A = 1'b0; cycles(E);
      Rot_B = 1'b1; cycles(E); Rot_A = 1'b1; cycles(E);
    end else begin
      Rot_A = 1'b0; cycles(E); Rot_B = 1'b0; cycles(E);
      Rot_A = 1'b1; cycles(E); Rot_B = 1'b1; cycles(E);
    end
  endtask

  task automatic press();
    Rot_C = 1'b1; cycles(E); Rot_C = 1'b0; cycles(E);
    m_sel = (m_sel + 1) % 3;
    @(negedge Fg_clk);
    check("step_sel_press", int'(Step_sel), m_sel);
  endtask

  task automatic set_limits(input int lo, input int hi);
    m_lo = lo; m_hi = hi;
    m_count = clamp(m_count);
    publish();
    Lo_lim = CNT_W'(lo); Hi_lim = CNT_W'(hi);
    cycles(2);
  endtask

  task automatic do_reset(input int lo, input int hi);
    Reset = 1'b1;
    Rot_A = 1'b1; Rot_B = 1'b1; Rot_C = 1'b0;
    Lo_lim = CNT_W'(lo); Hi_lim = CNT_W'(hi);
    cycles(3);
    exp_q.delete();
    @(negedge Fg_clk);
    check("reset_address", int'(address), 0);
    check("reset_freqchng", int'(FreqChng), 0);
    check("reset_step_sel", int'(Step_sel), 0);
    m_lo = lo; m_hi = hi; m_sel = 0; m_pub = 0;
    m_count = clamp(0);
    publish();
    Reset = 1'b0;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(0, 1800);

    // Five CW detents inside the first period publish once as 5.
    exp_q.push_back(5);
    m_pub = 5;
    for (int i = 0; i < 5; i++) detent(1'b1, 1'b0);
    settle();

    // Saturation at both limits with the largest step.
    press();
    press();
    set_limits(1750, 1800); settle();
    set_limits(0, 1800);
    detent(1'b1, 1'b1); settle();
    set_limits(0, 50); settle();
    set_limits(0, 1800);
    detent(1'b0, 1'b1); settle();
    press();

    // Short glitch on A must not register; a following CW detent must still count.
    Rot_A = 1'b0; cycles(DEB_CYC - 1); Rot_A = 1'b1; cycles(E);
    settle();
    detent(1'b1, 1'b1); settle();

    // Long button hold advances the step only once.
    Rot_C = 1'b1;
    cycles(10000);
    m_sel = (m_sel + 1) % 3;
    @(negedge Fg_clk);
    check("step_sel_hold", int'(Step_sel), m_sel);
    Rot_C = 1'b0; cycles(E);
    @(negedge Fg_clk);
    check("step_sel_release", int'(Step_sel), m_sel);

    // Detent timeout: B falls twice with A held high; each counts once.
    for (int k = 0; k < 2; k++) begin
      m_count = (m_count + step_tbl[m_sel] > m_hi) ? m_hi : m_count + step_tbl[m_sel];
      publish();
      Rot_B = 1'b0; cycles(TMO_CYC + 20);
      settle();
      Rot_B = 1'b1; cycles(E);
    end

    // Raising Lo_lim clamps the count; an unchanged tick gives no pulse.
    set_limits(300, 300); settle();
    set_limits(300, 1800);
    set_limits(800, 1800); settle();
    settle();

    // Inverted limits hold the count at Lo_lim.
    set_limits(900, 500); settle();
    set_limits(0, 1800);

    // Reset mid-debounce, with a nonzero Lo_lim applied on the first cycle after reset.
    Rot_B = 1'b0; cycles(3);
    do_reset(100, 1800);
    settle();
    detent(1'b1, 1'b1); settle();

    // Randomised mix of rotation, step presses and limit changes.
    for (int i = 0; i < 40; i++) begin
      int op = int'($urandom_range(0, 3));
      case (op)
        0: detent(1'b1, 1'b1);
        1: detent(1'b0, 1'b1);
        2: press();
        default: begin
          int lo = int'($urandom_range(0, 400));
          int hi = int'($urandom_range(lo + 50, 2047));
          set_limits(lo, hi);
        end
      endcase
      settle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
